instr_fetch_queue: RTL and testbench

- Instruction fetch stage that sits directly upstream of the Decoder.
- Reads 16-bit instructions as two byte reads over the 8-bit memory read port, little-endian: low byte at PC, high byte at PC+1.
- Buffers fetched instructions, each with its PC, in a small queue.
- Presents them to the decoder over a valid/ready handshake, and accepts PC redirects from Execute.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/instr_queue.sv | 50 +++++
 rtl/instr_fetch_queue.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch FSM states and the fetch-queue entry.
// Widths here set the layout of entries passed from fetch to decode.
package cpu_pkg;

    localparam int ADDR_W    = 16;
    localparam int INSTR_W   = 16;
    localparam int WORD_SIZE = INSTR_W / 8;
    localparam int MEM_SIZE  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        F_IDLE,
        F_LO,
        F_HI,
        F_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Small synchronous FIFO of fetched instructions with their PCs.
// Flush wins over push and pop; the head is read straight from storage.
module instr_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: two byte reads per 16-bit instruction, queued for decode.
// Redirects flush the queue; an outstanding byte read is drained, not dropped.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [7:0]                 mem_rdata,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [INSTR_W-1:0]         dec_instr,
    output logic [ADDR_W-1:0]          dec_pc,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [7:0]        lo_byte;

    logic              ack;
    logic              push;
    logic              pop;
    logic              room_now;
    logic              room_next;
    logic [CW-1:0]     count_after;
    logic [ADDR_W-1:0] redirect_even;
    logic [ADDR_W-1:0] pc_next;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign ack           = mem_req && mem_ack;
    assign dec_valid     = (q_count != '0) && !redirect_valid;
    assign pop           = dec_valid && dec_ready;
    assign push          = (state == F_HI) && ack && !redirect_valid;
    assign redirect_even = {redirect_pc[ADDR_W-1:1], 1'b0};
    assign pc_next       = fetch_pc + ADDR_W'(WORD_SIZE);

    // Occupancy as it will be after this cycle's push and pop.
    assign count_after = q_count + CW'(1) - CW'(pop);
    assign room_now    = fetch_en && !redirect_valid
                      && (q_count < CW'(DEPTH));
    assign room_next   = fetch_en && (count_after < CW'(DEPTH));

    assign push_entry.instr = {mem_rdata, lo_byte};
    assign push_entry.pc    = fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= F_IDLE;
            fetch_pc <= RESET_PC;
            lo_byte  <= '0;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            unique case (state)
                F_IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_even;
                    end else if (room_now) begin
                        state    <= F_LO;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                F_LO: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_even;
                        if (ack) begin
                            state   <= F_IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            state <= F_DRAIN;
                        end
                    end else if (ack) begin
                        lo_byte  <= mem_rdata;
                        state    <= F_HI;
                        mem_addr <= fetch_pc + ADDR_W'(1);
                    end
                end
                F_HI: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_even;
                        if (ack) begin
                            state   <= F_IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            state <= F_DRAIN;
                        end
                    end else if (ack) begin
                        fetch_pc <= pc_next;
                        if (room_next) begin
                            state    <= F_LO;
                            mem_addr <= pc_next;
                        end else begin
                            state   <= F_IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                F_DRAIN: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_even;
                    end
                    if (ack) begin
                        state   <= F_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= F_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    instr_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (q_count),
        .head       (head)
    );

    assign dec_instr = head.instr;
    assign dec_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: byte memory responder, stream scoreboard,
// directed scenarios and randomized fetch/redirect traffic.
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic [2:0]  q_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem [65536];
    logic [31:0] exp_q [$];

    int lat_mode  = 0;
    int remain    = 0;
    bit pending   = 0;
    bit force_ack = 0;

    instr_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .q_count        (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Expected decode stream: consecutive little-endian words from pc.
    task automatic model_restart(input logic [15:0] pc);
        logic [15:0] p;
        exp_q.delete();
        p = {pc[15:1], 1'b0};
        repeat (200) begin
            exp_q.push_back({mem[p + 16'd1], mem[p], p});
            p = p + 16'd2;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        model_restart(pc);
        step;
        redirect_valid = 1'b0;
    endtask

    // Memory: ack after lat_mode idle cycles (255 = random 0..3).
    always @(posedge clk) begin
        #1;
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'hEE;
            pending   = 0;
        end else if (rst || !mem_req) begin
            mem_ack = 1'b0;
            pending = 0;
        end else begin
            if (!pending) begin
                pending = 1;
                remain  = (lat_mode == 255) ? $urandom_range(0, 3)
                                            : lat_mode;
            end
            if (remain == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                pending   = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                remain--;
            end
        end
    end

    // Monitor: scoreboard pops, request stability, head hold.
    bit          prev_pend = 0;
    bit          prev_hold = 0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_head = '0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            prev_pend = 0;
            prev_hold = 0;
        end else begin
            if (prev_pend)
                chk("req_stable", {15'd0, mem_req, mem_addr},
                    {15'd0, 1'b1, prev_addr});
            if (prev_hold)
                chk("head_hold", {dec_instr, dec_pc}, prev_head);
            chk("q_bound", 32'(q_count <= 3'd4), 32'd1);
            if (dec_valid && dec_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_entry", {dec_instr, dec_pc}, e);
                end
            end
            prev_pend = mem_req && !mem_ack;
            prev_addr = mem_addr;
            prev_hold = dec_valid && !dec_ready;
            prev_head = {dec_instr, dec_pc};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        logic [15:0] old;
        logic [15:0] tgt;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h34;
        mem[1] = 8'h12;
        mem[2] = 8'h78;
        mem[3] = 8'h56;

        rst            = 1'b1;
        fetch_en       = 1'b1;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_ack        = 1'b0;
        mem_rdata      = '0;

        // Reset values and straight-line zero-wait fetch.
        repeat (3) @(posedge clk);
        neg;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_instr", 32'(dec_instr), 32'd0);
        chk("rst_pc", 32'(dec_pc), 32'd0);
        chk("rst_count", 32'(q_count), 32'd0);
        step;
        rst = 1'b0;
        model_restart(16'h0000);
        neg;
        chk("c0_req", 32'(mem_req), 32'd0);
        step; neg;
        chk("c1_req", {mem_req, mem_addr}, {1'b1, 16'h0000});
        step; neg;
        chk("c2_addr", {mem_req, mem_addr}, {1'b1, 16'h0001});
        chk("c2_valid", 32'(dec_valid), 32'd0);
        step; neg;
        chk("c3_valid", 32'(dec_valid), 32'd1);
        chk("c3_head", {dec_instr, dec_pc}, 32'h1234_0000);
        step; neg;
        chk("c4_valid", 32'(dec_valid), 32'd0);
        step; neg;
        chk("c5_valid", 32'(dec_valid), 32'd1);
        chk("c5_head", {dec_instr, dec_pc}, 32'h5678_0002);
        step;

        // Backpressure fills the queue and stops requests.
        lat_mode  = 1;
        dec_ready = 1'b0;
        do_redirect(16'h0200);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            neg;
            if (q_count == 3'd4) begin
                found = 1;
                break;
            end
        end
        chk("bp_full", 32'(found), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step; neg;
            chk("bp_noreq", 32'(mem_req), 32'd0);
            chk("bp_head", {dec_instr, dec_pc},
                {mem[16'h0201], mem[16'h0200], 16'h0200});
        end
        chk("bp_count", 32'(q_count), 32'd4);
        step;
        dec_ready = 1'b1;
        neg;
        step;
        dec_ready = 1'b0;
        neg;
        chk("bp_pop1", 32'(q_count), 32'd3);
        chk("bp_next_pc", 32'(dec_pc), 32'h0202);
        found = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req) begin
                found = 1;
                break;
            end
            step; neg;
        end
        chk("bp_restart", {found, mem_addr}, {1'b1, 16'h0208});

        // Redirect in F_HI with a slow ack: drain, then refetch even pc.
        step;
        lat_mode  = 3;
        dec_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            neg;
            if (mem_req && mem_addr[0] && !mem_ack && remain >= 1) begin
                found = 1;
                break;
            end
        end
        chk("rd_found", 32'(found), 32'd1);
        old = mem_addr;
        step;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0101;
        model_restart(16'h0101);
        neg;
        chk("rd_valid0", 32'(dec_valid), 32'd0);
        step;
        redirect_valid = 1'b0;
        neg;
        chk("rd_flush", 32'(q_count), 32'd0);
        chk("rd_hold", {mem_req, mem_addr}, {1'b1, old});
        found = 0;
        for (int i = 0; i < 10; i++) begin
            step; neg;
            if (!(mem_req && mem_addr == old)) begin
                found = 1;
                break;
            end
            chk("rd_nopush", 32'(q_count), 32'd0);
        end
        chk("rd_drained", 32'(found), 32'd1);
        found = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_req) begin
                found = 1;
                break;
            end
            step; neg;
        end
        chk("rd_newaddr", {found, mem_addr}, {1'b1, 16'h0100});

        // Redirect colliding with a pop and a hi-byte ack.
        step;
        lat_mode  = 0;
        dec_ready = 1'b0;
        tgt       = 16'($urandom);
        found     = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (mem_req && mem_addr[0] && q_count != 3'd0) begin
                found          = 1;
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                dec_ready      = 1'b1;
                model_restart(tgt);
                break;
            end
        end
        chk("col_found", 32'(found), 32'd1);
        neg;
        chk("col_valid0", 32'(dec_valid), 32'd0);
        step;
        redirect_valid = 1'b0;
        neg;
        chk("col_flush", 32'(q_count), 32'd0);
        chk("col_idle", 32'(mem_req), 32'd0);
        step; neg;
        chk("col_addr", {mem_req, mem_addr}, {1'b1, tgt[15:1], 1'b0});

        // Wrap-around from 0xFFFE to 0x0000.
        step;
        lat_mode = 255;
        do_redirect(16'hFFFE);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            neg;
            if (dec_valid) begin
                found = 1;
                break;
            end
            step;
        end
        chk("wr_first", {found, dec_instr, dec_pc},
            {1'b1, mem[16'hFFFF], mem[16'hFFFE], 16'hFFFE});
        step;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            neg;
            if (dec_valid) begin
                found = 1;
                break;
            end
            step;
        end
        chk("wr_second", {found, dec_pc}, {1'b1, 16'h0000});

        // Async reset mid-F_LO with a stale ack during reset.
        step;
        lat_mode  = 3;
        dec_ready = 1'b0;
        do_redirect(16'h0400);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            neg;
            if (q_count != 3'd0 && mem_req && !mem_addr[0]) begin
                found = 1;
                break;
            end
        end
        chk("ar_found", 32'(found), 32'd1);
        @(posedge clk);
        #3;
        rst       = 1'b1;
        force_ack = 1'b1;
        #1;
        chk("ar_req", 32'(mem_req), 32'd0);
        chk("ar_count", 32'(q_count), 32'd0);
        chk("ar_valid", 32'(dec_valid), 32'd0);
        chk("ar_addr", 32'(mem_addr), 32'd0);
        step;
        step;
        rst       = 1'b0;
        force_ack = 1'b0;
        dec_ready = 1'b1;
        model_restart(16'h0000);
        neg;
        chk("ar_c0", 32'(mem_req), 32'd0);
        step; neg;
        chk("ar_c1", {mem_req, mem_addr}, {1'b1, 16'h0000});
        step;
        lat_mode = 255;
        for (int i = 0; i < 40; i++) begin
            dec_ready = 1'($urandom);
            step;
        end

        // Randomized traffic with redirects and fetch_en toggling.
        for (int seg = 0; seg < 6; seg++) begin
            case (seg % 4)
                0: lat_mode = 255;
                1: lat_mode = 0;
                2: lat_mode = 1;
                default: lat_mode = 2;
            endcase
            do_redirect(16'($urandom));
            for (int i = 0; i < 150; i++) begin
                fetch_en  = ($urandom % 8) != 0;
                dec_ready = 1'($urandom);
                if ($urandom % 32 == 0) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = 16'($urandom);
                    model_restart(redirect_pc);
                end else begin
                    redirect_valid = 1'b0;
                end
                step;
            end
            redirect_valid = 1'b0;
            fetch_en       = 1'b1;
        end

        step;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
